// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, decode valid/ready port
// and the execute redirect port. The master modport is the fetch unit's view.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, id_valid, instruction, pc, fetch_fault,
    input  imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, instruction, pc, fetch_fault,
    output imem_ack, imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RISC-V instruction fetch: PC owner, single-outstanding imem reads, 2-entry queue to decode.
// Define IF_MISALIGN_TRAP_EN to halt in FAULT on a misaligned redirect target.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
);
`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2, FAULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;
`endif

  state_t      state_q, state_d, resume_st;
  logic [1:0]  count_q, count_d, slot;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] head_instr_q, head_pc_q, tail_instr_q, tail_pc_q;
  logic [31:0] tgt;
  logic        push, pop, halted;

`ifdef IF_MISALIGN_TRAP_EN
  logic fault_q, fault_d, misal;
  assign tgt    = bus.redirect_pc;
  assign misal  = |bus.redirect_pc[1:0];
  assign halted = (state_q == FAULT);
`else
  assign tgt    = bus.redirect_pc & 32'hFFFF_FFFC;
  assign halted = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    fpc_d     = fpc_q;
    push      = 1'b0;
    pop       = (count_q != 2'd0) && bus.id_ready;
    resume_st = WAIT;
`ifdef IF_MISALIGN_TRAP_EN
    fault_d = fault_q;
    if (fault_q) resume_st = FAULT;
`endif
    if (bus.redirect && !halted) begin
      // Redirect wins over ack and pop: flush, retarget, and discard any response.
      count_d = 2'd0;
      fpc_d   = tgt;
`ifdef IF_MISALIGN_TRAP_EN
      if (misal) begin
        fault_d   = 1'b1;
        resume_st = FAULT;
      end
`endif
      if ((state_q == WAIT || state_q == DROP) && !bus.imem_ack) state_d = DROP;
      else state_d = resume_st;
    end else begin
      push    = (state_q == WAIT) && bus.imem_ack;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) fpc_d = fpc_q + 32'd4;
      unique case (state_q)
        IDLE:    if (count_d != 2'd2) state_d = WAIT;
        WAIT:    if (bus.imem_ack && count_d == 2'd2) state_d = IDLE;
        DROP:    if (bus.imem_ack) state_d = resume_st;
        default: ;
      endcase
    end
    // The address may only move once the outstanding request has been acked.
    addr_d = (state_d == DROP) ? addr_q : fpc_d;
    slot   = count_q - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
`ifdef IF_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
`ifdef IF_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      head_instr_q <= tail_instr_q;
      head_pc_q    <= tail_pc_q;
    end
    if (push) begin
      if (slot == 2'd0) begin
        head_instr_q <= bus.imem_rdata;
        head_pc_q    <= addr_q;
      end else begin
        tail_instr_q <= bus.imem_rdata;
        tail_pc_q    <= addr_q;
      end
    end
  end

  assign bus.imem_req    = (state_q == WAIT) || (state_q == DROP);
  assign bus.imem_addr   = addr_q;
  assign bus.id_valid    = (count_q != 2'd0);
  assign bus.instruction = bus.id_valid ? head_instr_q : NOP_INSTR;
  assign bus.pc          = bus.id_valid ? head_pc_q : fpc_q;
`ifdef IF_MISALIGN_TRAP_EN
  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-configurable memory, stream-level delivery model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  int unsigned lat;
  int unsigned wcnt;
  int          n_chk;
  int          n_fail;
  logic [31:0] dlog[$];
  logic [31:0] exp_next;
  logic        post_redir;
  logic        hold_chk;
  logic [31:0] held_addr;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  function automatic logic [31:0] redirect_target(input logic [31:0] rp);
`ifdef IF_MISALIGN_TRAP_EN
    return rp;
`else
    return rp & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic [31:0] dget(input int i);
    if (i < dlog.size()) return dlog[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acks a held request after 'lat' waiting cycles (0 = same cycle).
  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  assign bus.imem_ack   = bus.imem_req && !rst && (wcnt >= lat);
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Stream model: decode must see consecutive words from the last target, each
  // carrying the memory word of its pc, and nothing right after a redirect.
  initial begin
    exp_next   = RESET_PC;
    post_redir = 1'b0;
    hold_chk   = 1'b0;
    held_addr  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_next   = RESET_PC;
        post_redir = 1'b0;
        hold_chk   = 1'b0;
      end else begin
        if (post_redir) chk("valid_after_redirect", {31'd0, bus.id_valid}, 32'd0);
        if (!bus.id_valid) chk("nop_when_empty", bus.instruction, NOP_INSTR);
        else chk("head_word", bus.instruction, mem_word(bus.pc));
        if (hold_chk) begin
          chk("req_held", {31'd0, bus.imem_req}, 32'd1);
          chk("addr_held", bus.imem_addr, held_addr);
        end
        if (bus.id_valid && bus.id_ready) begin
          chk("deliver_pc", bus.pc, exp_next);
          dlog.push_back(bus.pc);
          exp_next = exp_next + 32'd4;
        end
        if (bus.redirect) exp_next = redirect_target(bus.redirect_pc);
        post_redir = bus.redirect;
        hold_chk   = bus.imem_req && !bus.imem_ack;
        held_addr  = bus.imem_addr;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned l, input logic rdy);
    rst             = 1'b1;
    lat             = l;
    bus.id_ready    = rdy;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    dlog.delete();
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    next_cycle();
    bus.redirect = 1'b0;
    dlog.delete();
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    rst             = 1'b1;
    lat             = 0;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_instr", bus.instruction, 32'h0000_0013);
    chk("rst_pc", bus.pc, 32'h0000_0000);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);

    // Zero-wait streaming from reset release
    do_reset(0, 1'b1);
    @(negedge clk);
    chk("t1_req_c0", {31'd0, bus.imem_req}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t1_req_c1", {31'd0, bus.imem_req}, 32'd1);
    chk("t1_addr_c1", bus.imem_addr, 32'h0000_0000);
    chk("t1_valid_c1", {31'd0, bus.id_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t1_valid_c2", {31'd0, bus.id_valid}, 32'd1);
    chk("t1_pc_c2", bus.pc, 32'h0000_0000);
    next_cycle();
    @(negedge clk);
    chk("t1_pc_c3", bus.pc, 32'h0000_0004);
    next_cycle();
    @(negedge clk);
    chk("t1_pc_c4", bus.pc, 32'h0000_0008);

    // Backpressure: queue fills, requests stop, then drains in order
    next_cycle();
    do_reset(0, 1'b0);
    repeat (5) next_cycle();
    @(negedge clk);
    chk("t2_req_full", {31'd0, bus.imem_req}, 32'd0);
    chk("t2_valid_full", {31'd0, bus.id_valid}, 32'd1);
    chk("t2_pc_full", bus.pc, 32'h0000_0000);
    next_cycle();
    bus.id_ready = 1'b1;
    repeat (6) next_cycle();
    chk("t2_d0", dget(0), 32'h0000_0000);
    chk("t2_d1", dget(1), 32'h0000_0004);
    chk("t2_d2", dget(2), 32'h0000_0008);

    // 3-cycle memory, redirect in first wait cycle: stale word dropped
    do_reset(3, 1'b1);
    next_cycle();
    pulse_redirect(32'h0000_0100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("t3_req_drop", {31'd0, bus.imem_req}, 32'd1);
        chk("t3_addr_drop", bus.imem_addr, 32'h0000_0000);
      end
      chk("t3_no_stale", {31'd0, bus.id_valid}, 32'd0);
      next_cycle();
    end
    repeat (6) next_cycle();
    chk("t3_first_pc", dget(0), 32'h0000_0100);

    // Redirect coinciding with ack and pop
    do_reset(0, 1'b1);
    repeat (3) next_cycle();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    @(negedge clk);
    chk("t4_ack_same", {31'd0, bus.imem_ack}, 32'd1);
    chk("t4_pop_same", {31'd0, bus.id_valid}, 32'd1);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("t4_valid_next", {31'd0, bus.id_valid}, 32'd0);
    chk("t4_addr_next", bus.imem_addr, 32'h0000_0040);
    chk("t4_req_next", {31'd0, bus.imem_req}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("t4_pc_after", bus.pc, 32'h0000_0040);

    // PC wraps past the top of the address space
    next_cycle();
    pulse_redirect(32'hFFFF_FFFC);
    repeat (5) next_cycle();
    chk("t5_top", dget(0), 32'hFFFF_FFFC);
    chk("t5_wrap", dget(1), 32'h0000_0000);

    // Misaligned redirect
    pulse_redirect(32'h0000_0102);
`ifdef IF_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_fault", {31'd0, bus.fetch_fault}, 32'd1);
      chk("t6_req", {31'd0, bus.imem_req}, 32'd0);
      chk("t6_valid", {31'd0, bus.id_valid}, 32'd0);
      next_cycle();
    end
    do_reset(0, 1'b1);
    @(negedge clk);
    chk("t6_fault_clr", {31'd0, bus.fetch_fault}, 32'd0);
`else
    @(negedge clk);
    chk("t6_addr_aligned", bus.imem_addr, 32'h0000_0100);
    chk("t6_nofault", {31'd0, bus.fetch_fault}, 32'd0);
    repeat (4) next_cycle();
    chk("t6_first_pc", dget(0), 32'h0000_0100);
`endif

    // Reset while a request is outstanding
    next_cycle();
    do_reset(3, 1'b1);
    repeat (2) next_cycle();
    @(negedge clk);
    chk("t7_req_pend", {31'd0, bus.imem_req}, 32'd1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("t7_req_rst", {31'd0, bus.imem_req}, 32'd0);
    chk("t7_addr_rst", bus.imem_addr, 32'h0000_0000);
    chk("t7_valid_rst", {31'd0, bus.id_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
